// File: rtl/keccak_state_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keccak_state_mem_arbiter_pkg
// Description : Shared types and constants for the Keccak state memory
//               arbiter: FSM encoding, memory view selectors, default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package keccak_state_mem_arbiter_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TURN   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Memory view select; the client index doubles as its view (lane=0, slice=1)
  localparam logic MODE_LANE  = 1'b0;
  localparam logic MODE_SLICE = 1'b1;

  // Default geometry: 25 lanes x 64 bits, or 64 slices x 25 bits
  localparam int DEF_L_AW = 5;
  localparam int DEF_L_DW = 64;
  localparam int DEF_S_AW = 6;
  localparam int DEF_S_DW = 25;

  // Width of the turnaround counter (TURN_CYCLES is 1..7)
  localparam int TURN_CW = 3;

endpackage
`default_nettype wire

// File: rtl/keccak_state_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : keccak_state_mem_arbiter_if
// Description : Bundles both requester handshakes and the dual-view memory
//               port of the state memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface keccak_state_mem_arbiter_if
  import keccak_state_mem_arbiter_pkg::*;
#(
  parameter int L_AW = DEF_L_AW,
  parameter int L_DW = DEF_L_DW,
  parameter int S_AW = DEF_S_AW,
  parameter int S_DW = DEF_S_DW
) ();

  // Lane client
  logic            req_l;
  logic            we_l;
  logic            lock_l;
  logic [L_AW-1:0] adr_l;
  logic [L_DW-1:0] wdata_l;
  logic            ack_l;
  logic [L_DW-1:0] rdata_l;

  // Slice client
  logic            req_s;
  logic            we_s;
  logic            lock_s;
  logic [S_AW-1:0] adr_s;
  logic [S_DW-1:0] wdata_s;
  logic            ack_s;
  logic [S_DW-1:0] rdata_s;

  // Dual-view memory
  logic            mem_mode;
  logic            mem_r64;
  logic            mem_w64;
  logic [L_AW-1:0] mem_adr64;
  logic [L_DW-1:0] mem_in64;
  logic [L_DW-1:0] mem_out64;
  logic            mem_r25;
  logic            mem_w25;
  logic [S_AW-1:0] mem_adr25;
  logic [S_DW-1:0] mem_in25;
  logic [S_DW-1:0] mem_out25;

  // Arbiter side
  modport slave (
    input  req_l, we_l, lock_l, adr_l, wdata_l,
    output ack_l, rdata_l,
    input  req_s, we_s, lock_s, adr_s, wdata_s,
    output ack_s, rdata_s,
    output mem_mode,
    output mem_r64, mem_w64, mem_adr64, mem_in64,
    input  mem_out64,
    output mem_r25, mem_w25, mem_adr25, mem_in25,
    input  mem_out25
  );

  // Requesters plus memory side
  modport master (
    output req_l, we_l, lock_l, adr_l, wdata_l,
    input  ack_l, rdata_l,
    output req_s, we_s, lock_s, adr_s, wdata_s,
    input  ack_s, rdata_s,
    input  mem_mode,
    input  mem_r64, mem_w64, mem_adr64, mem_in64,
    output mem_out64,
    input  mem_r25, mem_w25, mem_adr25, mem_in25,
    output mem_out25
  );

endinterface
`default_nettype wire

// File: rtl/keccak_state_mem_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin grant with lock. Bit 0 is the lane
//               client, bit 1 the slice client. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import keccak_state_mem_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_lock,
  input  logic       i_owner,
  output logic [1:0] o_grant
);

  // Locked: only the owner may win. Contended: the non-owner wins.
  always_comb begin
    o_grant = 2'b00;
    if (i_lock) begin
      if (i_req[i_owner]) begin
        o_grant[i_owner] = 1'b1;
      end
    end else if (&i_req) begin
      o_grant[~i_owner] = 1'b1;
    end else begin
      o_grant = i_req;
    end
  end

endmodule
`default_nettype wire

// File: rtl/keccak_state_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : keccak_state_mem_arbiter
// Description : Shares the dual-view Keccak state memory between the lane
//               client (64-bit view) and the slice client (25-bit view).
//               Owns the view select and strobes, inserts turnaround cycles
//               on every view change. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module keccak_state_mem_arbiter
  import keccak_state_mem_arbiter_pkg::*;
#(
  parameter int L_AW        = DEF_L_AW,
  parameter int L_DW        = DEF_L_DW,
  parameter int S_AW        = DEF_S_AW,
  parameter int S_DW        = DEF_S_DW,
  parameter int TURN_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  keccak_state_mem_arbiter_if.slave     bus,
  output logic                          busy,
  output logic                          owner
);

  localparam logic [TURN_CW-1:0] c_turn_load = TURN_CW'(TURN_CYCLES - 1);

  // Control state
  state_t             r_state,    w_state_nxt;
  logic               r_mode,     w_mode_nxt;
  logic               r_owner,    w_owner_nxt;
  logic               r_lock,     w_lock_nxt;
  logic [TURN_CW-1:0] r_turn_cnt, w_turn_nxt;
  logic               r_busy,     w_busy_nxt;

  // Latched command of the current winner
  logic               r_win,      w_win_nxt;
  logic               r_we,       w_we_nxt;
  logic [L_AW-1:0]    r_adr_l,    w_adr_l_nxt;
  logic [S_AW-1:0]    r_adr_s,    w_adr_s_nxt;
  logic [L_DW-1:0]    r_wdata_l,  w_wdata_l_nxt;
  logic [S_DW-1:0]    r_wdata_s,  w_wdata_s_nxt;

  // Registered client outputs
  logic               r_ack_l,    w_ack_l_nxt;
  logic               r_ack_s,    w_ack_s_nxt;
  logic [L_DW-1:0]    r_rdata_l,  w_rdata_l_nxt;
  logic [S_DW-1:0]    r_rdata_s,  w_rdata_s_nxt;

  // Registered memory outputs
  logic               r_r64,      w_r64_nxt;
  logic               r_w64,      w_w64_nxt;
  logic [L_AW-1:0]    r_adr64,    w_adr64_nxt;
  logic [L_DW-1:0]    r_in64,     w_in64_nxt;
  logic               r_r25,      w_r25_nxt;
  logic               r_w25,      w_w25_nxt;
  logic [S_AW-1:0]    r_adr25,    w_adr25_nxt;
  logic [S_DW-1:0]    r_in25,     w_in25_nxt;

  // Arbitration
  logic [1:0]         w_req;
  logic [1:0]         w_grant;
  logic               w_sel_win;
  logic               w_sel_we;
  logic               w_sel_lock;
  logic               w_go;

  assign w_req      = {bus.req_s, bus.req_l};
  assign w_sel_win  = w_grant[1];
  assign w_sel_we   = w_sel_win ? bus.we_s   : bus.we_l;
  assign w_sel_lock = w_sel_win ? bus.lock_s : bus.lock_l;

  rr_arbiter2 u_arb (
    .i_req   (w_req),
    .i_lock  (r_lock),
    .i_owner (r_owner),
    .o_grant (w_grant)
  );

  // Next-state and next-output logic for the arbiter FSM
  always_comb begin
    w_state_nxt   = r_state;
    w_mode_nxt    = r_mode;
    w_owner_nxt   = r_owner;
    w_lock_nxt    = r_lock;
    w_turn_nxt    = r_turn_cnt;
    w_win_nxt     = r_win;
    w_we_nxt      = r_we;
    w_adr_l_nxt   = r_adr_l;
    w_adr_s_nxt   = r_adr_s;
    w_wdata_l_nxt = r_wdata_l;
    w_wdata_s_nxt = r_wdata_s;
    w_ack_l_nxt   = 1'b0;
    w_ack_s_nxt   = 1'b0;
    w_rdata_l_nxt = r_rdata_l;
    w_rdata_s_nxt = r_rdata_s;
    w_go          = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (|w_grant) begin
          w_win_nxt     = w_sel_win;
          w_we_nxt      = w_sel_we;
          w_adr_l_nxt   = bus.adr_l;
          w_adr_s_nxt   = bus.adr_s;
          w_wdata_l_nxt = bus.wdata_l;
          w_wdata_s_nxt = bus.wdata_s;
          w_owner_nxt   = w_sel_win;
          w_lock_nxt    = w_sel_lock;
          if (w_sel_win == r_mode) begin
            w_state_nxt = ST_ACCESS;
            w_go        = 1'b1;
          end else begin
            // View change: flip the mode now so it is stable through TURN
            w_mode_nxt  = ~r_mode;
            w_turn_nxt  = c_turn_load;
            w_state_nxt = ST_TURN;
          end
        end else if (r_lock && !w_req[r_owner]) begin
          // Locked owner let go of its request: release the lock
          w_lock_nxt = 1'b0;
        end
      end

      ST_TURN: begin
        if (r_turn_cnt == '0) begin
          w_state_nxt = ST_ACCESS;
          w_go        = 1'b1;
        end else begin
          w_turn_nxt = r_turn_cnt - 1'b1;
        end
      end

      ST_ACCESS: begin
        w_state_nxt = ST_DONE;
        if (r_win == MODE_SLICE) begin
          w_ack_s_nxt = 1'b1;
          if (!r_we) begin
            w_rdata_s_nxt = bus.mem_out25;
          end
        end else begin
          w_ack_l_nxt = 1'b1;
          if (!r_we) begin
            w_rdata_l_nxt = bus.mem_out64;
          end
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Memory strobes, address and data are only non-zero during ACCESS
    w_r64_nxt   = 1'b0;
    w_w64_nxt   = 1'b0;
    w_adr64_nxt = '0;
    w_in64_nxt  = '0;
    w_r25_nxt   = 1'b0;
    w_w25_nxt   = 1'b0;
    w_adr25_nxt = '0;
    w_in25_nxt  = '0;
    if (w_go) begin
      if (w_win_nxt == MODE_SLICE) begin
        w_r25_nxt   = ~w_we_nxt;
        w_w25_nxt   = w_we_nxt;
        w_adr25_nxt = w_adr_s_nxt;
        w_in25_nxt  = w_wdata_s_nxt;
      end else begin
        w_r64_nxt   = ~w_we_nxt;
        w_w64_nxt   = w_we_nxt;
        w_adr64_nxt = w_adr_l_nxt;
        w_in64_nxt  = w_wdata_l_nxt;
      end
    end

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State and output registers; reset abandons any access in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_mode     <= MODE_LANE;
      r_owner    <= MODE_SLICE;
      r_lock     <= 1'b0;
      r_turn_cnt <= '0;
      r_busy     <= 1'b0;
      r_win      <= 1'b0;
      r_we       <= 1'b0;
      r_adr_l    <= '0;
      r_adr_s    <= '0;
      r_wdata_l  <= '0;
      r_wdata_s  <= '0;
      r_ack_l    <= 1'b0;
      r_ack_s    <= 1'b0;
      r_rdata_l  <= '0;
      r_rdata_s  <= '0;
      r_r64      <= 1'b0;
      r_w64      <= 1'b0;
      r_adr64    <= '0;
      r_in64     <= '0;
      r_r25      <= 1'b0;
      r_w25      <= 1'b0;
      r_adr25    <= '0;
      r_in25     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_mode     <= w_mode_nxt;
      r_owner    <= w_owner_nxt;
      r_lock     <= w_lock_nxt;
      r_turn_cnt <= w_turn_nxt;
      r_busy     <= w_busy_nxt;
      r_win      <= w_win_nxt;
      r_we       <= w_we_nxt;
      r_adr_l    <= w_adr_l_nxt;
      r_adr_s    <= w_adr_s_nxt;
      r_wdata_l  <= w_wdata_l_nxt;
      r_wdata_s  <= w_wdata_s_nxt;
      r_ack_l    <= w_ack_l_nxt;
      r_ack_s    <= w_ack_s_nxt;
      r_rdata_l  <= w_rdata_l_nxt;
      r_rdata_s  <= w_rdata_s_nxt;
      r_r64      <= w_r64_nxt;
      r_w64      <= w_w64_nxt;
      r_adr64    <= w_adr64_nxt;
      r_in64     <= w_in64_nxt;
      r_r25      <= w_r25_nxt;
      r_w25      <= w_w25_nxt;
      r_adr25    <= w_adr25_nxt;
      r_in25     <= w_in25_nxt;
    end
  end

  assign bus.ack_l     = r_ack_l;
  assign bus.rdata_l   = r_rdata_l;
  assign bus.ack_s     = r_ack_s;
  assign bus.rdata_s   = r_rdata_s;
  assign bus.mem_mode  = r_mode;
  assign bus.mem_r64   = r_r64;
  assign bus.mem_w64   = r_w64;
  assign bus.mem_adr64 = r_adr64;
  assign bus.mem_in64  = r_in64;
  assign bus.mem_r25   = r_r25;
  assign bus.mem_w25   = r_w25;
  assign bus.mem_adr25 = r_adr25;
  assign bus.mem_in25  = r_in25;
  assign busy          = r_busy;
  assign owner         = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_keccak_state_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_keccak_state_mem_arbiter
// Description : Directed self-checking bench. Two arbiters (TURN_CYCLES 1
//               and 3) share one dual-view memory model; a per-client
//               scoreboard holds the expected access and read data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keccak_state_mem_arbiter;
  import keccak_state_mem_arbiter_pkg::*;

  typedef struct packed {
    logic        we;
    logic [5:0]  adr;
    logic [63:0] wdata;
    logic [63:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic cur;
  logic mem_load;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  keccak_state_mem_arbiter_if ifa ();
  keccak_state_mem_arbiter_if ifb ();
  logic busy_a, owner_a, busy_b, owner_b;

  keccak_state_mem_arbiter #(.TURN_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa), .busy(busy_a), .owner(owner_a));
  keccak_state_mem_arbiter #(.TURN_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb), .busy(busy_b), .owner(owner_b));

  // Requester drive, steered to the arbiter under test
  logic        d_req_l, d_we_l, d_lock_l, d_req_s, d_we_s, d_lock_s;
  logic [4:0]  d_adr_l;
  logic [63:0] d_wdata_l;
  logic [5:0]  d_adr_s;
  logic [24:0] d_wdata_s;
  logic [63:0] mem_out64;
  logic [24:0] mem_out25;

  assign ifa.req_l = d_req_l & ~cur;
  assign ifb.req_l = d_req_l & cur;
  assign ifa.req_s = d_req_s & ~cur;
  assign ifb.req_s = d_req_s & cur;
  assign ifa.we_l = d_we_l;     assign ifb.we_l = d_we_l;
  assign ifa.lock_l = d_lock_l; assign ifb.lock_l = d_lock_l;
  assign ifa.adr_l = d_adr_l;   assign ifb.adr_l = d_adr_l;
  assign ifa.wdata_l = d_wdata_l; assign ifb.wdata_l = d_wdata_l;
  assign ifa.we_s = d_we_s;     assign ifb.we_s = d_we_s;
  assign ifa.lock_s = d_lock_s; assign ifb.lock_s = d_lock_s;
  assign ifa.adr_s = d_adr_s;   assign ifb.adr_s = d_adr_s;
  assign ifa.wdata_s = d_wdata_s; assign ifb.wdata_s = d_wdata_s;
  assign ifa.mem_out64 = mem_out64; assign ifb.mem_out64 = mem_out64;
  assign ifa.mem_out25 = mem_out25; assign ifb.mem_out25 = mem_out25;

  // Observed outputs of the arbiter under test
  logic        m_ack_l, m_ack_s, m_mode, m_r64, m_w64, m_r25, m_w25, m_busy, m_owner;
  logic [63:0] m_rdata_l, m_in64;
  logic [24:0] m_rdata_s, m_in25;
  logic [4:0]  m_adr64;
  logic [5:0]  m_adr25;

  assign m_ack_l   = cur ? ifb.ack_l     : ifa.ack_l;
  assign m_ack_s   = cur ? ifb.ack_s     : ifa.ack_s;
  assign m_rdata_l = cur ? ifb.rdata_l   : ifa.rdata_l;
  assign m_rdata_s = cur ? ifb.rdata_s   : ifa.rdata_s;
  assign m_mode    = cur ? ifb.mem_mode  : ifa.mem_mode;
  assign m_r64     = cur ? ifb.mem_r64   : ifa.mem_r64;
  assign m_w64     = cur ? ifb.mem_w64   : ifa.mem_w64;
  assign m_adr64   = cur ? ifb.mem_adr64 : ifa.mem_adr64;
  assign m_in64    = cur ? ifb.mem_in64  : ifa.mem_in64;
  assign m_r25     = cur ? ifb.mem_r25   : ifa.mem_r25;
  assign m_w25     = cur ? ifb.mem_w25   : ifa.mem_w25;
  assign m_adr25   = cur ? ifb.mem_adr25 : ifa.mem_adr25;
  assign m_in25    = cur ? ifb.mem_in25  : ifa.mem_in25;
  assign m_busy    = cur ? busy_b        : busy_a;
  assign m_owner   = cur ? owner_b       : owner_a;

  function automatic logic [63:0] init_lane(int i);
    return 64'hC3A5_5A3C_0000_0000 ^ (64'(i) * 64'h0001_0203_0405_0607);
  endfunction

  // Dual-view state memory: slice z bit i is lane i bit z
  logic [63:0] mem [25];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 25; i++) mem[i] <= init_lane(i);
    end else begin
      if (m_w64 && m_adr64 < 5'd25) mem[m_adr64] <= m_in64;
      if (m_w25) for (int i = 0; i < 25; i++) mem[i][m_adr25] <= m_in25[i];
    end
  end

  always_comb begin
    mem_out64 = (m_adr64 < 5'd25) ? mem[m_adr64] : 64'd0;
    mem_out25 = '0;
    for (int i = 0; i < 25; i++) mem_out25[i] = mem[i][m_adr25];
  end

  // Reference contents and scoreboard
  logic [63:0] sh [25];
  logic [63:0] last_l;
  logic [24:0] last_s;
  exp_t        q_l[$];
  exp_t        q_s[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_l(input logic we, input logic [4:0] adr, input logic [63:0] wd);
    exp_t e;
    if (we) sh[adr] = wd;
    else    last_l  = sh[adr];
    e.we = we; e.adr = {1'b0, adr}; e.wdata = wd; e.rdata = last_l;
    q_l.push_back(e);
  endtask

  task automatic push_s(input logic we, input logic [5:0] adr, input logic [24:0] wd);
    exp_t e;
    for (int i = 0; i < 25; i++) begin
      if (we) sh[i][adr] = wd[i];
      else    last_s[i]  = sh[i][adr];
    end
    e.we = we; e.adr = adr; e.wdata = 64'(wd); e.rdata = 64'(last_s);
    q_s.push_back(e);
  endtask

  task automatic req_l(input logic we, input logic [4:0] adr, input logic [63:0] wd, input logic lk);
    d_we_l = we; d_adr_l = adr; d_wdata_l = wd; d_lock_l = lk; d_req_l = 1'b1;
    push_l(we, adr, wd);
  endtask

  task automatic req_s(input logic we, input logic [5:0] adr, input logic [24:0] wd, input logic lk);
    d_we_s = we; d_adr_s = adr; d_wdata_s = wd; d_lock_s = lk; d_req_s = 1'b1;
    push_s(we, adr, wd);
  endtask

  // Waits for the next ack, checking the one access it belongs to
  task automatic wait_ack(input logic exp_cl, input int exp_lat, input logic drop);
    int          edges   = 0;
    int          strobes = 0;
    logic        got     = 1'b0;
    logic        mode_ok = 1'b1;
    logic        sv_view = 1'b0;
    logic        sv_we   = 1'b0;
    logic [5:0]  sv_adr  = '0;
    logic [63:0] sv_wd   = '0;
    exp_t        e       = '0;
    while (!got && edges < 40) begin
      @(negedge clk);
      edges++;
      if (m_r64 | m_w64 | m_r25 | m_w25) begin
        strobes++;
        sv_view = m_r25 | m_w25;
        sv_we   = m_w64 | m_w25;
        sv_adr  = sv_view ? m_adr25 : {1'b0, m_adr64};
        sv_wd   = sv_view ? 64'(m_in25) : m_in64;
        if (m_mode != sv_view) mode_ok = 1'b0;
        if ((m_r64 | m_w64) && (m_r25 | m_w25)) mode_ok = 1'b0;
      end
      if (m_ack_l | m_ack_s) got = 1'b1;
    end
    chk("ack_seen", 64'(got), 64'd1);
    if (got) begin
      chk("ack_client", 64'(m_ack_s), 64'(exp_cl));
      chk("ack_onehot", 64'(m_ack_l & m_ack_s), 64'd0);
      if (exp_lat >= 0) chk("latency", 64'(edges), 64'(exp_lat));
      chk("strobe_cycles", 64'(strobes), 64'd1);
      chk("mode_vs_view", 64'(mode_ok), 64'd1);
      chk("strobe_view", 64'(sv_view), 64'(m_ack_s));
      if (m_ack_s) begin
        chk("sb_nonempty", 64'(q_s.size() != 0), 64'd1);
        if (q_s.size() != 0) e = q_s.pop_front();
        chk("rdata_s", 64'(m_rdata_s), e.rdata);
      end else begin
        chk("sb_nonempty", 64'(q_l.size() != 0), 64'd1);
        if (q_l.size() != 0) e = q_l.pop_front();
        chk("rdata_l", m_rdata_l, e.rdata);
      end
      chk("strobe_we", 64'(sv_we), 64'(e.we));
      chk("strobe_adr", 64'(sv_adr), 64'(e.adr));
      if (e.we) chk("strobe_wdata", sv_wd, e.wdata);
      if (drop) begin
        if (m_ack_s) d_req_s = 1'b0;
        else         d_req_l = 1'b0;
      end
    end
  endtask

  task automatic idle_gap();
    @(negedge clk);
    chk("busy_idle", 64'(m_busy), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cur = 1'b0; mem_load = 1'b1;
    d_req_l = 0; d_we_l = 0; d_lock_l = 0; d_adr_l = '0; d_wdata_l = '0;
    d_req_s = 0; d_we_s = 0; d_lock_s = 0; d_adr_s = '0; d_wdata_s = '0;
    last_l = '0; last_s = '0;
    for (int i = 0; i < 25; i++) sh[i] = init_lane(i);
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_mode", 64'(ifa.mem_mode), 64'd0);
    chk("rst_owner", 64'(owner_a), 64'd1);
    chk("rst_owner_b", 64'(owner_b), 64'd1);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_acks", 64'({ifa.ack_l, ifa.ack_s}), 64'd0);
    chk("rst_strobes", 64'({ifa.mem_r64, ifa.mem_w64, ifa.mem_r25, ifa.mem_w25}), 64'd0);
    chk("rst_rdata_l", ifa.rdata_l, 64'd0);
    chk("rst_rdata_s", 64'(ifa.rdata_s), 64'd0);
    rst = 1'b0; mem_load = 1'b0;
    @(negedge clk);

    // Slice write then lane read across the view change (TURN_CYCLES=1)
    req_s(1'b1, 6'd3, 25'b00000_11101_00000_00000_00000, 1'b0);
    wait_ack(1'b1, 3, 1'b1);
    idle_gap();
    chk("mode_after_slice", 64'(m_mode), 64'd1);
    req_l(1'b0, 5'd3, 64'd0, 1'b0);
    wait_ack(1'b0, 3, 1'b1);
    idle_gap();
    chk("mode_after_lane", 64'(m_mode), 64'd0);

    // Lane write then lane read, same view
    req_l(1'b1, 5'd3, 64'hFFFF_FFFF_FFFF_FF55, 1'b0);
    wait_ack(1'b0, 2, 1'b1);
    idle_gap();
    req_l(1'b0, 5'd3, 64'd0, 1'b0);
    wait_ack(1'b0, 2, 1'b1);
    idle_gap();

    // Both request straight out of reset: L, S, L, S
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_owner", 64'(m_owner), 64'd1);
    last_l = '0; last_s = '0;
    rst = 1'b0;
    req_l(1'b0, 5'd5, 64'd0, 1'b0);
    req_s(1'b0, 6'd2, 25'd0, 1'b0);
    push_l(1'b0, 5'd5, 64'd0);
    push_s(1'b0, 6'd2, 25'd0);
    wait_ack(1'b0, 2, 1'b0);
    wait_ack(1'b1, -1, 1'b0);
    wait_ack(1'b0, -1, 1'b1);
    wait_ack(1'b1, -1, 1'b1);
    idle_gap();

    // Lane locks for three accesses while slice waits
    req_l(1'b0, 5'd0, 64'd0, 1'b1);
    req_s(1'b0, 6'd7, 25'd0, 1'b0);
    wait_ack(1'b0, -1, 1'b0);
    for (int k = 1; k < 4; k++) begin
      d_adr_l = 5'(k);
      d_lock_l = (k < 3);
      push_l(1'b0, 5'(k), 64'd0);
      wait_ack(1'b0, -1, 1'b0);
    end
    chk("lock_owner", 64'(m_owner), 64'd0);
    push_l(1'b0, 5'd3, 64'd0);
    wait_ack(1'b1, -1, 1'b1);
    wait_ack(1'b0, -1, 1'b1);
    idle_gap();

    // Reset during the ACCESS cycle of a lane write
    d_we_l = 1'b1; d_adr_l = 5'd10; d_wdata_l = 64'h0123_4567_89AB_CDEF; d_lock_l = 1'b0;
    d_req_l = 1'b1;
    @(negedge clk);
    chk("abort_w64", 64'(m_w64), 64'd1);
    chk("abort_adr", 64'(m_adr64), 64'd10);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ack", 64'({m_ack_l, m_ack_s}), 64'd0);
    chk("abort_strobes", 64'({m_r64, m_w64, m_r25, m_w25}), 64'd0);
    chk("abort_mode", 64'(m_mode), 64'd0);
    chk("abort_busy", 64'(m_busy), 64'd0);
    chk("abort_owner", 64'(m_owner), 64'd1);
    chk("abort_rdata", m_rdata_l, 64'd0);
    sh[10] = 64'h0123_4567_89AB_CDEF;
    last_l = '0; last_s = '0;
    d_req_l = 1'b0; rst = 1'b0;
    @(negedge clk);
    req_l(1'b0, 5'd10, 64'd0, 1'b0);
    wait_ack(1'b0, 2, 1'b1);
    idle_gap();

    // TURN_CYCLES=3: alternating reads, each one changes view
    cur = 1'b1;
    last_l = '0; last_s = '0;
    @(negedge clk);
    req_s(1'b0, 6'd2, 25'd0, 1'b0);
    wait_ack(1'b1, 5, 1'b1);
    idle_gap();
    req_l(1'b0, 5'd4, 64'd0, 1'b0);
    wait_ack(1'b0, 5, 1'b1);
    idle_gap();
    req_s(1'b0, 6'd9, 25'd0, 1'b0);
    wait_ack(1'b1, 5, 1'b1);
    idle_gap();
    req_l(1'b0, 5'd0, 64'd0, 1'b0);
    wait_ack(1'b0, 5, 1'b1);
    idle_gap();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
